// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: drains the TX FIFO and serialises each character as
// start / 5-8 data bits (LSB first) / optional parity / 1, 1.5 or 2 stop bits.
module uart_tx_ctrl #(
  parameter int FIFO_CW = 5,
  parameter int DW      = 8
) (
  input  logic               clk,
  input  logic               wb_rst_i,
  input  logic               enable,
  input  logic [7:0]         lcr,
  input  logic [DW-1:0]      fifo_data,
  input  logic [FIFO_CW-1:0] fifo_count,
  output logic               fifo_pop,
  output logic               stx_o,
  output logic               tx_busy,
  output logic               tx_empty
);

  // state  | meaning
  // IDLE   | line high, waiting for FIFO data
  // POP    | one clk: pop FIFO, load shifter, latch frame config
  // START  | start bit (low) for one bit period
  // DATA   | 5-8 data bits, LSB first
  // PARITY | optional parity bit
  // STOP   | stop bits: 16, 24 or 32 enables
  typedef enum logic [2:0] {IDLE, POP, START, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  logic [3:0]    r_tick;
  logic [2:0]    r_bit;
  logic [4:0]    r_stop_cnt;
  logic [DW-1:0] r_shift;
  logic [5:0]    r_cfg;
  logic          r_par;

  logic       w_fifo_nonempty;
  logic       w_bit_end;
  logic [2:0] w_last_bit;
  logic [4:0] w_stop_last;
  logic       w_stop_end;
  logic       w_par_bit;
  logic       w_line;
  logic       w_unused;

  assign w_unused        = lcr[7];
  assign w_fifo_nonempty = (fifo_count != '0);
  assign w_bit_end       = enable && (r_tick == 4'd15);
  assign w_last_bit      = 3'd4 + {1'b0, r_cfg[1:0]};
  assign w_stop_last     = !r_cfg[2] ? 5'd15 :
                           (r_cfg[1:0] == 2'b00) ? 5'd23 : 5'd31;
  assign w_stop_end      = enable && (r_stop_cnt == w_stop_last);
  // r_par holds the XOR of the bits actually shifted out
  assign w_par_bit       = r_cfg[5] ? ~r_cfg[4] : (r_cfg[4] ? r_par : ~r_par);

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      START:   w_line = 1'b0;
      DATA:    w_line = r_shift[0];
      PARITY:  w_line = w_par_bit;
      default: w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bit      <= '0;
      r_stop_cnt <= '0;
      r_shift    <= '0;
      r_cfg      <= '0;
      r_par      <= 1'b0;
      fifo_pop   <= 1'b0;
      stx_o      <= 1'b1;
      tx_busy    <= 1'b0;
      tx_empty   <= 1'b1;
    end else begin
      fifo_pop <= 1'b0;
      // break uses the live LCR bit so it takes effect on the next clk
      stx_o    <= w_line & ~lcr[6];
      tx_empty <= (r_state == IDLE) && !w_fifo_nonempty;
      case (r_state)
        IDLE: begin
          if (w_fifo_nonempty) begin
            r_state  <= POP;
            fifo_pop <= 1'b1;
            tx_busy  <= 1'b1;
          end
        end
        POP: begin
          r_shift    <= fifo_data;
          r_cfg      <= lcr[5:0];
          r_par      <= 1'b0;
          r_tick     <= '0;
          r_bit      <= '0;
          r_stop_cnt <= '0;
          r_state    <= START;
        end
        START: begin
          if (enable) begin
            r_tick <= r_tick + 4'd1;
            if (w_bit_end) begin
              r_bit   <= '0;
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (enable) begin
            r_tick <= r_tick + 4'd1;
            if (w_bit_end) begin
              r_shift <= {1'b0, r_shift[DW-1:1]};
              r_par   <= r_par ^ r_shift[0];
              if (r_bit == w_last_bit) begin
                r_stop_cnt <= '0;
                r_state    <= r_cfg[3] ? PARITY : STOP;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end
          end
        end
        PARITY: begin
          if (enable) begin
            r_tick <= r_tick + 4'd1;
            if (w_bit_end) begin
              r_stop_cnt <= '0;
              r_state    <= STOP;
            end
          end
        end
        STOP: begin
          if (enable) begin
            if (w_stop_end) begin
              r_stop_cnt <= '0;
              if (w_fifo_nonempty) begin
                r_state  <= POP;
                fifo_pop <= 1'b1;
              end else begin
                r_state <= IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 5'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table-driven frames, hand-written corner sequences and
// randomized traffic checked against a per-enable line model built from framing rules.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       enable;
  logic [7:0] lcr;
  logic [7:0] fifo_data;
  logic [4:0] fifo_count;
  logic       fifo_pop, stx_o, tx_busy, tx_empty;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.FIFO_CW(5), .DW(8)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .lcr(lcr),
    .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_pop(fifo_pop),
    .stx_o(stx_o), .tx_busy(tx_busy), .tx_empty(tx_empty)
  );

  typedef struct {
    logic [7:0] lcr;
    logic [7:0] data;
    int         gap;
    string      seq;      // expected bit periods in send order: start, data, parity
    int         stop_en;  // expected stop length in enables
  } vec_t;

  vec_t vecs[10];

  int n_pass = 0, n_total = 0;
  logic [7:0] fifo_q[$];
  bit obs[$], brk[$], exp_q[$];
  int runs[$];
  int run_len = 0;
  bit line_prev = 1'b1;
  int npops = 0, gap = 1, cyc = 0;
  bit en_d = 0, busy_d = 0, pop_d = 0, brk_d = 0, pop_now = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic sync_fifo();
    fifo_count = 5'(fifo_q.size());
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Reference: one line level per enable from start bit through the last stop enable.
  task automatic model_frame(input logic [7:0] d, input logic [7:0] l);
    int nb = 5 + int'(l[1:0]);
    bit px = 1'b0;
    bit p;
    int stop;
    repeat (16) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (16) exp_q.push_back(d[i]);
      px ^= d[i];
    end
    if (l[3]) begin
      p = l[5] ? !l[4] : (l[4] ? px : !px);
      repeat (16) exp_q.push_back(p);
    end
    stop = !l[2] ? 16 : ((nb == 5) ? 24 : 32);
    repeat (stop) exp_q.push_back(1'b1);
  endtask

  // One clk: drive enable, sample at negedge, retire a popped FIFO entry after the edge.
  task automatic tick();
    enable = (gap > 0) && (cyc % gap == 0);
    @(negedge clk);
    if (en_d && busy_d && !pop_d) begin
      obs.push_back(stx_o);
      brk.push_back(brk_d);
    end
    if (stx_o == line_prev) run_len++;
    else begin
      runs.push_back(run_len);
      run_len   = 1;
      line_prev = stx_o;
    end
    pop_now = fifo_pop;
    if (fifo_pop) begin
      npops++;
      check(fifo_q.size() != 0, "pop_with_fifo_nonempty", int'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) model_frame(fifo_q[0], lcr);
    end
    en_d = enable; busy_d = tx_busy; pop_d = fifo_pop; brk_d = lcr[6];
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    sync_fifo();
    cyc++;
  endtask

  task automatic clear_logs();
    obs.delete(); brk.delete(); exp_q.delete(); runs.delete();
    npops = 0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(fifo_q.size() == 0 && tx_empty && !tx_busy) && n < budget);
    check(n < budget, name, n, budget);
  endtask

  task automatic compare_model(input string name);
    int bad = -1;
    check(obs.size() == exp_q.size(), {name, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      if (bad < 0 && obs[i] != (exp_q[i] & !brk[i])) bad = i;
    check(bad < 0, {name, "_first_bad_sample"}, bad, -1);
  endtask

  initial begin
    bit rq[$];
    int bad, lows, highs, n, pushed, nch;

    vecs[0] = '{8'h03, 8'hA5, 1, "010100101",  16};
    vecs[1] = '{8'h1A, 8'h41, 1, "010000010",  16};
    vecs[2] = '{8'h04, 8'h1F, 1, "011111",     24};
    vecs[3] = '{8'h07, 8'h3C, 1, "000111100",  32};
    vecs[4] = '{8'h05, 8'h2A, 1, "0010101",    32};
    vecs[5] = '{8'h0B, 8'hAA, 2, "0010101011", 16};
    vecs[6] = '{8'h1B, 8'h07, 3, "0111000001", 16};
    vecs[7] = '{8'h2B, 8'h01, 1, "0100000001", 16};
    vecs[8] = '{8'h3B, 8'h7F, 4, "0111111100", 16};
    vecs[9] = '{8'h1C, 8'hE6, 1, "0011000",    24};

    wb_rst_i = 1'b0; enable = 1'b0; lcr = 8'h00;
    sync_fifo();
    repeat (3) @(posedge clk);
    #1;
    check(stx_o == 1'b1,    "reset_stx",      int'(stx_o), 1);
    check(tx_empty == 1'b1, "reset_tx_empty", int'(tx_empty), 1);
    check(tx_busy == 1'b0,  "reset_tx_busy",  int'(tx_busy), 0);
    check(fifo_pop == 1'b0, "reset_fifo_pop", int'(fifo_pop), 0);
    wb_rst_i = 1'b1;

    // idle with empty FIFO
    clear_logs();
    lows = 0;
    for (int t = 0; t < 1000; t++) begin
      tick();
      if (!stx_o) lows++;
    end
    check(lows == 0,        "idle_line_low_clks", lows, 0);
    check(npops == 0,       "idle_pops", npops, 0);
    check(tx_empty == 1'b1, "idle_tx_empty", int'(tx_empty), 1);

    // table-driven single frames
    for (int r = 0; r < 10; r++) begin
      clear_logs();
      gap = vecs[r].gap;
      lcr = vecs[r].lcr;
      fifo_q.push_back(vecs[r].data);
      sync_fifo();
      run_until_idle(2000, "row_timeout");
      rq.delete();
      for (int i = 0; i < vecs[r].seq.len(); i++)
        repeat (16) rq.push_back(vecs[r].seq[i] == "1");
      repeat (vecs[r].stop_en) rq.push_back(1'b1);
      bad = -1;
      for (int i = 0; i < obs.size() && i < rq.size(); i++)
        if (bad < 0 && obs[i] != rq[i]) bad = i;
      check(obs.size() == rq.size(), $sformatf("row%0d_enables", r), obs.size(), rq.size());
      check(bad < 0, $sformatf("row%0d_first_bad_sample", r), bad, -1);
      check(npops == 1, $sformatf("row%0d_pops", r), npops, 1);
      check(tx_empty == 1'b1, $sformatf("row%0d_tx_empty", r), int'(tx_empty), 1);
    end

    // back-to-back frames with an LCR write during the first frame's data bits
    clear_logs();
    gap = 1; lcr = 8'h03;
    fifo_q.push_back(8'h55); fifo_q.push_back(8'hAA);
    sync_fifo();
    repeat (40) tick();
    lcr = 8'h0B;
    run_until_idle(1000, "b2b_timeout");
    check(npops == 2, "b2b_pops", npops, 2);
    check(runs.size() > 10 && runs[1] == 16, "b2b_start_clks", (runs.size() > 1) ? runs[1] : -1, 16);
    check(runs.size() > 10 && runs[10] == 17, "b2b_stop_plus_gap_clks", (runs.size() > 10) ? runs[10] : -1, 17);
    check(obs.size() == 336, "b2b_total_enables", obs.size(), 336);
    check(obs.size() > 304 && obs[304] == 1'b1, "b2b_second_parity", (obs.size() > 304) ? int'(obs[304]) : -1, 1);
    compare_model("b2b");

    // enable every 4th clk: data bits last 64 clk
    clear_logs();
    gap = 4; lcr = 8'h03;
    fifo_q.push_back(8'h55);
    sync_fifo();
    run_until_idle(2000, "x4_timeout");
    check(runs.size() > 6 && runs[2] == 64, "x4_bit0_clks", (runs.size() > 2) ? runs[2] : -1, 64);
    check(runs.size() > 6 && runs[5] == 64, "x4_bit3_clks", (runs.size() > 5) ? runs[5] : -1, 64);
    compare_model("x4");

    // break asserted mid-character: line held low, FIFO still drains
    clear_logs();
    gap = 1; lcr = 8'h03;
    fifo_q.push_back(8'h0F); fifo_q.push_back(8'hF0);
    sync_fifo();
    repeat (30) tick();
    lcr = 8'h43;
    highs = 0; n = 0;
    do begin
      tick();
      n++;
      if (stx_o) highs++;
    end while (!(fifo_q.size() == 0 && tx_empty && !tx_busy) && n < 3000);
    check(n < 3000, "brk_timeout", n, 3000);
    check(highs == 0, "brk_line_high_clks", highs, 0);
    check(npops == 2, "brk_pops", npops, 2);
    check(fifo_q.size() == 0, "brk_fifo_drained", fifo_q.size(), 0);
    compare_model("brk");
    lcr = 8'h03;
    tick();
    check(stx_o == 1'b1, "brk_release_line", int'(stx_o), 1);

    // asynchronous reset in the middle of DATA
    clear_logs();
    gap = 1; lcr = 8'h03;
    fifo_q.push_back(8'h55);
    sync_fifo();
    repeat (30) tick();
    check(tx_busy == 1'b1, "abort_busy_before", int'(tx_busy), 1);
    #2;
    wb_rst_i = 1'b0;
    #1;
    check(stx_o == 1'b1,    "abort_stx",      int'(stx_o), 1);
    check(tx_busy == 1'b0,  "abort_tx_busy",  int'(tx_busy), 0);
    check(tx_empty == 1'b1, "abort_tx_empty", int'(tx_empty), 1);
    check(fifo_pop == 1'b0, "abort_fifo_pop", int'(fifo_pop), 0);
    repeat (3) tick();
    wb_rst_i = 1'b1;
    clear_logs();
    repeat (50) tick();
    check(npops == 0, "abort_pops_after_release", npops, 0);
    check(stx_o == 1'b1, "abort_line_after_release", int'(stx_o), 1);

    // randomized traffic: random framing, spacing, pushes, LCR writes and break
    for (int b = 0; b < 8; b++) begin
      clear_logs();
      gap = $urandom_range(1, 4);
      lcr = {1'b0, ($urandom_range(0, 3) == 0), 6'($urandom)};
      nch = $urandom_range(1, 4);
      pushed = 0;
      for (int k = 0; k < nch; k++) begin
        fifo_q.push_back(8'($urandom));
        pushed++;
      end
      sync_fifo();
      for (int t = 0; t < 1500; t++) begin
        tick();
        if ($urandom_range(0, 299) == 0) lcr = 8'($urandom) & 8'h7F;
        if ($urandom_range(0, 399) == 0 && fifo_q.size() < 16) begin
          fifo_q.push_back(8'($urandom));
          pushed++;
          sync_fifo();
        end
      end
      run_until_idle(8000, $sformatf("rand%0d_timeout", b));
      check(npops == pushed, $sformatf("rand%0d_pops", b), npops, pushed);
      compare_model($sformatf("rand%0d", b));
      lcr[6] = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
